// File: rtl/board_draw.sv
// Scans a snapshot of the 8x8 reversi board into the VGA pixel-write port, one pixel per clock.
// Optional grid lines: define BOARD_DRAW_GRID_EN to draw px=0/py=0 pixels in black.
module board_draw #(
    parameter int CELL_PX = 14,
    parameter int X0      = 24,
    parameter int Y0      = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [127:0] board,
    output logic [7:0]   vga_x,
    output logic [6:0]   vga_y,
    output logic [2:0]   colour,
    output logic         plot,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [3:0] PX_LAST = 4'(CELL_PX - 1);

    state_t       state;
    logic [127:0] snap;
    logic [2:0]   cx, cy;
    logic [3:0]   px, py;

    logic [1:0]   code;
    logic [2:0]   pix_colour;
    logic         grid_px;
    logic         last_pixel;

    always_comb begin
        code = snap[{cy, cx, 1'b0} +: 2];
        case (code)
            2'b00:   pix_colour = 3'b010;
            2'b01:   pix_colour = 3'b110;
            2'b10:   pix_colour = 3'b111;
            default: pix_colour = 3'b000;
        endcase
`ifdef BOARD_DRAW_GRID_EN
        grid_px = (px == 4'd0) || (py == 4'd0);
`else
        grid_px = 1'b0;
`endif
        if (grid_px)
            pix_colour = 3'b000;
        last_pixel = (cx == 3'd7) && (cy == 3'd7) && (px == PX_LAST) && (py == PX_LAST);
    end

    // NOTE: all state here, including the 128-bit snapshot, uses non-blocking
    // assignments and is cleared by the async reset so restarts are deterministic.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            snap   <= '0;
            cx     <= '0;
            cy     <= '0;
            px     <= '0;
            py     <= '0;
            vga_x  <= '0;
            vga_y  <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            plot <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap  <= board;
                        cx    <= '0;
                        cy    <= '0;
                        px    <= '0;
                        py    <= '0;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    // Address is formed at full integer width and truncated to the port.
                    vga_x  <= 8'(X0 + int'(cx) * CELL_PX + int'(px));
                    vga_y  <= 7'(Y0 + int'(cy) * CELL_PX + int'(py));
                    colour <= pix_colour;
                    plot   <= 1'b1;
                    busy   <= 1'b1;
                    if (px == PX_LAST) begin
                        px <= '0;
                        if (py == PX_LAST) begin
                            py <= '0;
                            cx <= cx + 3'd1;
                            if (cx == 3'd7)
                                cy <= cy + 3'd1;
                        end else begin
                            py <= py + 4'd1;
                        end
                    end else begin
                        px <= px + 4'd1;
                    end
                    if (last_pixel)
                        state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_draw.sv
// Bench for board_draw: frame-level model indexed by cycles since start, plus literal pins.
module tb_board_draw;

    localparam int C    = 14;
    localparam int X0   = 24;
    localparam int Y0   = 4;
    localparam int NPIX = 64 * C * C;
`ifdef BOARD_DRAW_GRID_EN
    localparam int GRID = 1;
`else
    localparam int GRID = 0;
`endif

    localparam logic [127:0] INIT_B  = {48'h0, 16'h02C0, 16'h0380, 48'h0};
    localparam logic [127:0] BLACK_B = {128{1'b1}};
    localparam logic [127:0] WHITE_B = {64{2'b10}};

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [127:0] board;
    logic [7:0]   vga_x;
    logic [6:0]   vga_y;
    logic [2:0]   colour;
    logic         plot, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    board_draw #(.CELL_PX(C), .X0(X0), .Y0(Y0)) dut (
        .clk(clk), .resetn(resetn), .start(start), .board(board),
        .vga_x(vga_x), .vga_y(vga_y), .colour(colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_k counts edges since start was accepted (-1 = idle).
    int           m_k = -1;
    logic [127:0] m_snap = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_k    <= -1;
            m_snap <= '0;
        end else if (m_k >= 0 && m_k <= NPIX) begin
            m_k <= m_k + 1;
        end else if (start) begin
            m_k    <= 0;
            m_snap <= board;
        end else begin
            m_k <= -1;
        end
    end

    function automatic int model_colour(input int i, input logic [127:0] s);
        int pal[4];
        int px, py, cx, cy;
        logic [1:0] code;
        pal = '{2, 6, 7, 0};
        px = i % C;
        py = (i / C) % C;
        cx = (i / (C * C)) % 8;
        cy = i / (C * C * 8);
        code = s[(cy * 8 + cx) * 2 +: 2];
        if (GRID == 1 && (px == 0 || py == 0))
            return 0;
        return pal[code];
    endfunction

    int cap_a, cap_g0, cap_g1;

    always @(negedge clk) begin
        int i, ep;
        if (resetn) begin
            ep = (m_k >= 1 && m_k <= NPIX) ? 1 : 0;
            check("plot", int'(plot), ep);
            check("busy", int'(busy), ep);
            check("done", int'(done), (m_k == NPIX + 1) ? 1 : 0);
            if (ep == 1) begin
                i = m_k - 1;
                check("vga_x", int'(vga_x), (X0 + ((i / (C * C)) % 8) * C + i % C) % 256);
                check("vga_y", int'(vga_y), (Y0 + (i / (C * C * 8)) * C + (i / C) % C) % 128);
                check("colour", int'(colour), model_colour(i, m_snap));
            end
            if (m_k == 0) begin
                cap_a  = -1;
                cap_g0 = -1;
                cap_g1 = -1;
            end
            if (plot) begin
                if (vga_x == 8'd71 && vga_y == 7'd51) cap_a  = int'(colour);
                if (vga_x == 8'd38 && vga_y == 7'd7)  cap_g0 = int'(colour);
                if (vga_x == 8'd39 && vga_y == 7'd7)  cap_g1 = int'(colour);
            end
        end
    end

    task automatic run_frame(input logic [127:0] b, input bit hold,
                             output int npl, output int done_k,
                             output int fx, output int fy, output int fc,
                             output int lx, output int ly);
        bit first;
        @(posedge clk);
        #2 board = b;
        start = 1'b1;
        @(posedge clk);
        #2 if (!hold) start = 1'b0;
        npl = 0; done_k = -1; first = 1'b1;
        fx = -1; fy = -1; fc = -1; lx = -1; ly = -1;
        for (int k = 0; k <= NPIX + 20; k++) begin
            @(negedge clk);
            if (plot) begin
                if (first) begin
                    fx = int'(vga_x); fy = int'(vga_y); fc = int'(colour);
                    first = 1'b0;
                end
                lx = int'(vga_x); ly = int'(vga_y);
                npl++;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
    endtask

    initial begin
        int npl, dk, fx, fy, fc, lx, ly;
        resetn = 1'b0; start = 1'b0; board = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vga_x", int'(vga_x), 0);
        check("rst_vga_y", int'(vga_y), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk) resetn = 1'b1;

        // Abort a frame at pixel 500 with an asynchronous reset.
        @(posedge clk);
        #2 board = INIT_B; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (500) @(posedge clk);
        #2 check("pre_abort_plot", int'(plot), 1);
        resetn = 1'b0;
        #1;
        check("abort_plot", int'(plot), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_vga_x", int'(vga_x), 0);
        check("abort_vga_y", int'(vga_y), 0);
        check("abort_colour", int'(colour), 0);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        repeat (5) @(negedge clk) check("no_done_after_abort", int'(done), 0);

        // Initial reversi position.
        run_frame(INIT_B, 1'b0, npl, dk, fx, fy, fc, lx, ly);
        check("init_plot_count", npl, 12544);
        check("init_done_cycle", dk, 12545);
        check("init_first_x", fx, 24);
        check("init_first_y", fy, 4);
        check("init_first_colour", fc, (GRID == 1) ? 0 : 2);
        check("init_cell33_colour", cap_a, 7);

        // All-black board.
        run_frame(BLACK_B, 1'b0, npl, dk, fx, fy, fc, lx, ly);
        check("black_plot_count", npl, 12544);
        check("black_last_x", lx, 135);
        check("black_last_y", ly, 115);
        check("black_first_colour", fc, 0);
        check("black_cell33_colour", cap_a, 0);

        // Snapshot: board turns white 10 cycles into an empty frame.
        fork
            run_frame(128'h0, 1'b0, npl, dk, fx, fy, fc, lx, ly);
            begin
                repeat (12) @(posedge clk);
                #3 board = WHITE_B;
            end
        join
        check("snap_plot_count", npl, 12544);
        check("snap_cell33_colour", cap_a, 2);
        check("snap_grid_px0_colour", cap_g0, (GRID == 1) ? 0 : 2);
        check("snap_px1_colour", cap_g1, 2);

        // start held high across a whole frame.
        run_frame(INIT_B, 1'b1, npl, dk, fx, fy, fc, lx, ly);
        check("held_plot_count", npl, 12544);
        check("held_done_cycle", dk, 12545);
        @(negedge clk) check("held_idle_plot", int'(plot), 0);
        @(negedge clk) check("held_restart_plot", int'(plot), 1);
        #2 start = 1'b0;
        repeat (20) @(posedge clk);
        #2 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("final_reset_plot", int'(plot), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
